// File: rtl/embedded_system_mem_arb_pkg.sv
// ============================================================================
// embedded_system_mem_arb_pkg
// Shared widths and master-index constants for the two-master RAM arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package embedded_system_mem_arb_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Byte-lane count for a given data width
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/embedded_system_rr_arbiter2.sv
// ============================================================================
// embedded_system_rr_arbiter2
// Two-input round-robin arbiter: combinational grant, 1-bit fairness pointer.
// Rev 1.0
// ============================================================================
`default_nettype none

module embedded_system_rr_arbiter2
    import embedded_system_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic r_rr;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (r_rr == M1) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer moves to whichever master lost (or was absent) this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= M0;
        end else if (grant[0]) begin
            r_rr <= M1;
        end else if (grant[1]) begin
            r_rr <= M0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/embedded_system_onchip_memory_arbiter.sv
// ============================================================================
// embedded_system_onchip_memory_arbiter
// Shares one single-port on-chip RAM between two masters, returns read data.
// Rev 1.0
// ============================================================================
`default_nettype none

module embedded_system_onchip_memory_arbiter
    import embedded_system_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_any_grant;
    logic              w_sel;
    logic              w_sel_write;
    logic [BE_W-1:0]   w_sel_be;

    logic              r_rd_valid;
    logic              r_rd_tag;

    assign w_req[0] = m0_read | m0_write;
    assign w_req[1] = m1_read | m1_write;

    embedded_system_rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .grant (w_grant)
    );

    assign w_any_grant = |w_grant;
    assign w_sel       = w_grant[1] ? M1 : M0;

    assign m0_waitrequest = w_req[0] & ~w_grant[0];
    assign m1_waitrequest = w_req[1] & ~w_grant[1];

    // Write wins when a master raises read and write together
    assign w_sel_write = (w_sel == M1) ? m1_write : m0_write;
    assign w_sel_be    = (w_sel == M1) ? m1_byteenable : m0_byteenable;

    assign mem_address    = (w_sel == M1) ? m1_address   : m0_address;
    assign mem_writedata  = (w_sel == M1) ? m1_writedata : m0_writedata;
    assign mem_byteenable = w_sel_write ? w_sel_be : {BE_W{1'b1}};
    assign mem_chipselect = w_any_grant;
    assign mem_write      = w_any_grant & w_sel_write;
    assign mem_clken      = ~reset;

    // RAM output appears one cycle after the granted read; tag records the owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_tag   <= M0;
        end else begin
            r_rd_valid <= w_any_grant & ~w_sel_write;
            r_rd_tag   <= w_sel;
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rd_valid & (r_rd_tag == M0);
    assign m1_readdatavalid = r_rd_valid & (r_rd_tag == M1);

endmodule

`default_nettype wire

// File: tb/tb_embedded_system_onchip_memory_arbiter.sv
// ============================================================================
// tb_embedded_system_onchip_memory_arbiter
// Directed bench with a synchronous RAM model behind the arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_embedded_system_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    embedded_system_onchip_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Synchronous RAM: registered address, unregistered output. Preloaded once.
    logic [31:0] ram [0:1023];
    logic [31:0] ram_q;
    bit          ram_loaded;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | i;
            ram_loaded <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_q <= ram[mem_address];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_all();
        m0_address = 10'h005; m1_address = 10'h000;
        m0_writedata = 0; m1_writedata = 0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_read = 1;
        step(); step();
        @(negedge clk);
        total++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin
            bad++; $display("FAIL reset_waitreq got=%b exp=10", {m0_waitrequest, m1_waitrequest});
        end
        total++;
        if ({mem_chipselect, mem_write, mem_clken, m0_readdatavalid, m1_readdatavalid} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=00000",
                {mem_chipselect, mem_write, mem_clken, m0_readdatavalid, m1_readdatavalid});
        end
        step();
        idle_all(); reset = 0;
        @(negedge clk);
        total++;
        if ({mem_clken, mem_chipselect, m0_waitrequest, m1_waitrequest} !== 4'b1000) begin
            bad++; $display("FAIL post_reset_idle got=%b exp=1000",
                {mem_clken, mem_chipselect, m0_waitrequest, m1_waitrequest});
        end
    endtask

    task automatic test_single_write();
        step();
        m0_write = 1; m0_address = 10'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        total++;
        if ({m0_waitrequest, mem_chipselect, mem_write, mem_address, mem_writedata, mem_byteenable}
            !== {1'b0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF}) begin
            bad++; $display("FAIL m0_write_grant got=%b%b%b addr=%h wd=%h be=%h exp=011 010 deadbeef f",
                m0_waitrequest, mem_chipselect, mem_write, mem_address, mem_writedata, mem_byteenable);
        end
        step();
        idle_all();
        m1_write = 1; m1_address = 10'h011; m1_writedata = 32'h0000_5A5A; m1_byteenable = 4'h3;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_waitrequest, mem_write, mem_address, mem_byteenable}
            !== {1'b0, 1'b0, 1'b1, 10'h011, 4'h3}) begin
            bad++; $display("FAIL m1_partial_write got=%b%b%b addr=%h be=%h exp=001 011 3",
                m0_readdatavalid, m1_waitrequest, mem_write, mem_address, mem_byteenable);
        end
        step();
        idle_all();
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            bad++; $display("FAIL write_no_valid got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
        end
    endtask

    task automatic test_read_be();
        step();
        m1_read = 1; m1_address = 10'h020; m1_byteenable = 4'h1;
        @(negedge clk);
        total++;
        if ({m1_waitrequest, mem_chipselect, mem_write, mem_byteenable} !== {3'b010, 4'hF}) begin
            bad++; $display("FAIL read_be_force got=%b%b%b be=%h exp=010 f",
                m1_waitrequest, mem_chipselect, mem_write, mem_byteenable);
        end
        step();
        idle_all(); m1_byteenable = 4'hF;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, 32'hA500_0020}) begin
            bad++; $display("FAIL read_be_return got=%b%b data=%h exp=01 a5000020",
                m0_readdatavalid, m1_readdatavalid, m1_readdata);
        end
        step();
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            bad++; $display("FAIL read_be_single got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
        end
    endtask

    task automatic test_contention();
        step();
        m0_read = 1; m0_address = 10'h010;
        m1_read = 1; m1_address = 10'h020;
        @(negedge clk);
        total++;
        if ({m0_waitrequest, m1_waitrequest, mem_address} !== {2'b01, 10'h010}) begin
            bad++; $display("FAIL contend_t got=%b%b addr=%h exp=01 010",
                m0_waitrequest, m1_waitrequest, mem_address);
        end
        step();
        m0_read = 0;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_waitrequest, mem_address}
            !== {2'b10, 32'hDEADBEEF, 1'b0, 10'h020}) begin
            bad++; $display("FAIL contend_t1 got=%b%b data=%h wr=%b addr=%h exp=10 deadbeef 0 020",
                m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_waitrequest, mem_address);
        end
        step();
        m1_read = 0;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, 32'hA500_0020}) begin
            bad++; $display("FAIL contend_t2 got=%b%b data=%h exp=01 a5000020",
                m0_readdatavalid, m1_readdatavalid, m1_readdata);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = 0;
        int v1 = 0;
        logic [31:0] exp_data;
        step();
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                m0_read = 1; m0_address = 10'(k);
                m1_read = 1; m1_address = 10'(10'h100 + k);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (k < 8) begin
                total++;
                if ({m0_waitrequest, m1_waitrequest, mem_chipselect} !== ((k % 2 == 0) ? 3'b011 : 3'b101)) begin
                    bad++; $display("FAIL b2b_grant cycle=%0d got=%b%b%b", k,
                        m0_waitrequest, m1_waitrequest, mem_chipselect);
                end
            end
            if (k > 0) begin
                exp_data = ((k - 1) % 2 == 0) ? (32'hA500_0000 | ((k - 1) / 2 * 0 + (k - 1)))
                                              : (32'hA500_0100 | (k - 1));
                total++;
                if ({m0_readdatavalid, m1_readdatavalid, m0_readdata}
                    !== {(((k - 1) % 2 == 0) ? 2'b10 : 2'b01), exp_data}) begin
                    bad++; $display("FAIL b2b_return cycle=%0d got=%b%b data=%h exp_data=%h", k,
                        m0_readdatavalid, m1_readdatavalid, m0_readdata, exp_data);
                end
            end
            if (m0_readdatavalid) v0++;
            if (m1_readdatavalid) v1++;
            step();
        end
        total++;
        if (v0 != 4 || v1 != 4) begin
            bad++; $display("FAIL b2b_counts got=%0d/%0d exp=4/4", v0, v1);
        end
    endtask

    task automatic test_reset_mid_read();
        m0_read = 1; m0_address = 10'h010;
        @(negedge clk);
        total++;
        if (m0_waitrequest !== 1'b0) begin
            bad++; $display("FAIL mid_read_grant got=%b exp=0", m0_waitrequest);
        end
        step();
        reset = 1; m1_read = 1; m1_address = 10'h020;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken} !== 5'b01100) begin
            bad++; $display("FAIL mid_read_reset got=%b exp=01100",
                {m0_readdatavalid, m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken});
        end
        step();
        reset = 0;
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest} !== 4'b0001) begin
            bad++; $display("FAIL post_reset_rr got=%b exp=0001",
                {m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest});
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_rw_both();
        m0_read = 1; m0_write = 1; m0_address = 10'h3FF;
        m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
        @(negedge clk);
        total++;
        if ({m0_waitrequest, mem_write, mem_address, mem_writedata} !== {2'b01, 10'h3FF, 32'h12345678}) begin
            bad++; $display("FAIL rw_both_write got=%b%b addr=%h wd=%h exp=01 3ff 12345678",
                m0_waitrequest, mem_write, mem_address, mem_writedata);
        end
        step();
        idle_all();
        @(negedge clk);
        total++;
        if (m0_readdatavalid !== 1'b0) begin
            bad++; $display("FAIL rw_both_novalid got=%b exp=0", m0_readdatavalid);
        end
        step();
        m0_read = 1;
        step();
        idle_all();
        @(negedge clk);
        total++;
        if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h12345678}) begin
            bad++; $display("FAIL rw_both_readback got=%b data=%h exp=1 12345678",
                m0_readdatavalid, m0_readdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_be();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_rw_both();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
